// File: rtl/dma_chan_regs_if.sv
// Bus and engine-side signal bundle for dma_chan_regs: register read/write handshake
// plus per-channel beat request/acknowledge and the aggregated interrupt.
interface dma_chan_regs_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic [NUM_CH-1:0] xfer_req;
    logic [NUM_CH-1:0] xfer_ack;
    logic              irq;

    modport master (
        output wr_en, rd_en, addr, wdata, xfer_ack,
        input  rdata, rd_valid, xfer_req, irq
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata, xfer_ack,
        output rdata, rd_valid, xfer_req, irq
    );
endinterface

// File: rtl/dma_chan_regs.sv
// Multi-channel DMA register bank: CTRL/SRC/LEN/STATUS per channel, IDLE/BUSY beat sequencer,
// W1C status and registered interrupt. STATUS.ERR is only implemented when DMA_REGS_ERR_EN is defined.
module dma_chan_regs #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input logic            clk,
    input logic            rst,
    dma_chan_regs_if.slave bus
);
    localparam int CH_W = ADDR_W - 2;
    localparam int SW   = (LEN_W + 16 > DATA_W) ? LEN_W + 16 : DATA_W;
    localparam logic [1:0] R_CTRL = 2'd0;
    localparam logic [1:0] R_SRC  = 2'd1;
    localparam logic [1:0] R_LEN  = 2'd2;
`ifdef DMA_REGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q   [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [LEN_W-1:0]  cnt_q     [NUM_CH];
    logic [LEN_W-1:0]  cnt_nxt   [NUM_CH];
    logic [LEN_W-1:0]  len_q     [NUM_CH];
    logic [LEN_W-1:0]  len_nxt   [NUM_CH];
    logic [DATA_W-1:0] src_q     [NUM_CH];
    logic [DATA_W-1:0] src_nxt   [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_nxt, ie_q, ie_nxt;
    logic [NUM_CH-1:0] done_q, done_nxt, err_q, err_nxt;

    logic [CH_W-1:0]   ch_idx;
    logic [1:0]        reg_idx;
    logic [DATA_W-1:0] rd_mux;
    logic [SW-1:0]     stat_w;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              irq_q;

    assign ch_idx  = bus.addr[ADDR_W-1:2];
    assign reg_idx = bus.addr[1:0];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_nxt[c] = state_q[c];
            cnt_nxt[c]   = cnt_q[c];
            len_nxt[c]   = len_q[c];
            src_nxt[c]   = src_q[c];
            en_nxt[c]    = en_q[c];
            ie_nxt[c]    = ie_q[c];
            done_nxt[c]  = done_q[c];
            err_nxt[c]   = err_q[c];

            if (bus.wr_en && ch_idx == CH_W'(c)) begin
                case (reg_idx)
                    R_CTRL: begin
                        en_nxt[c] = bus.wdata[0];
                        ie_nxt[c] = bus.wdata[2];
                        if (state_q[c] == IDLE) begin
                            if (bus.wdata[1]) begin
                                if (bus.wdata[0] && len_q[c] != '0) begin
                                    state_nxt[c] = BUSY;
                                    cnt_nxt[c]   = len_q[c];
                                end else begin
                                    err_nxt[c] = 1'b1;
                                end
                            end
                        end else if (!bus.wdata[0]) begin
                            // abort keeps the remaining count visible for software
                            state_nxt[c] = IDLE;
                            err_nxt[c]   = 1'b1;
                        end else if (bus.wdata[1]) begin
                            err_nxt[c] = 1'b1;
                        end
                    end
                    R_SRC: begin
                        if (state_q[c] == IDLE) src_nxt[c] = bus.wdata;
                        else                    err_nxt[c] = 1'b1;
                    end
                    R_LEN: begin
                        if (state_q[c] == IDLE) len_nxt[c] = bus.wdata[LEN_W-1:0];
                        else                    err_nxt[c] = 1'b1;
                    end
                    default: begin
                        if (bus.wdata[1]) done_nxt[c] = 1'b0;
                        if (bus.wdata[2]) err_nxt[c]  = 1'b0;
                    end
                endcase
            end

            // beat accounting runs after the W1C clear so a completing beat wins over it
            if (state_q[c] == BUSY && state_nxt[c] == BUSY && bus.xfer_ack[c]) begin
                cnt_nxt[c] = cnt_q[c] - LEN_W'(1);
                if (cnt_q[c] == LEN_W'(1)) begin
                    state_nxt[c] = IDLE;
                    done_nxt[c]  = 1'b1;
                end
            end

            if (!ERR_EN) err_nxt[c] = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        stat_w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                case (reg_idx)
                    R_CTRL: begin
                        rd_mux[0] = en_q[c];
                        rd_mux[2] = ie_q[c];
                    end
                    R_SRC:  rd_mux = src_q[c];
                    R_LEN:  rd_mux = DATA_W'(len_q[c]);
                    default: begin
                        stat_w[0]          = (state_q[c] == BUSY);
                        stat_w[1]          = done_q[c];
                        stat_w[2]          = err_q[c];
                        stat_w[LEN_W+15:16] = cnt_q[c];
                        rd_mux             = stat_w[DATA_W-1:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                len_q[c]   <= '0;
                src_q[c]   <= '0;
            end
            en_q     <= '0;
            ie_q     <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_nxt[c];
                cnt_q[c]   <= cnt_nxt[c];
                len_q[c]   <= len_nxt[c];
                src_q[c]   <= src_nxt[c];
            end
            en_q   <= en_nxt;
            ie_q   <= ie_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            // read stage: samples pre-write register state, holds between reads
            if (bus.rd_en) rdata_p1 <= rd_mux;
            vld_p1 <= bus.rd_en;
            irq_q  <= |(done_q & ie_q);
        end
    end

    always_comb begin
        bus.xfer_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.xfer_req[c] = (state_q[c] == BUSY);
        end
    end

    assign bus.rdata    = rdata_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.irq      = irq_q;
endmodule
